// File: rtl/render_pkg.sv
// Shared types for the render frame sequencer: camera location payload and sequencer states.
package render_pkg;

   localparam int unsigned CAMERA_LOC_W = 30;
   localparam int unsigned TRI_CNT_W    = 6;
   localparam int unsigned FRAME_CNT_W  = 8;

   typedef struct packed {
      logic [8:0]        angle;
      logic signed [6:0] x;
      logic signed [6:0] y;
      logic signed [6:0] z;
   } camera_loc_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LAUNCH,
      WAIT_TRI,
      RASTER,
      DRAIN,
      DONE
   } seq_state_t;

endpackage

// File: rtl/render_frame_sequencer_addr_sweep.sv
// addr_sweep: walks addr 0..count-1, one address per cycle, after a start pulse.
module addr_sweep #(
   parameter int unsigned ADDRW = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ADDRW:0]   count,
   output logic [ADDRW-1:0] addr,
   output logic             active,
   output logic             last
);

   // last is precomputed one cycle ahead so it is high together with the final address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr   <= '0;
         active <= 1'b0;
         last   <= 1'b0;
      end else if (start) begin
         addr   <= '0;
         active <= (count != '0);
         last   <= (count == (ADDRW+1)'(1));
      end else if (active) begin
         if (last) begin
            addr   <= '0;
            active <= 1'b0;
            last   <= 1'b0;
         end else begin
            addr   <= addr + ADDRW'(1);
            last   <= ((ADDRW+1)'({1'b0, addr}) + (ADDRW+1)'(2)) == count;
         end
      end
   end

endmodule

// File: rtl/render_frame_sequencer.sv
// Frame sequencer: clears the render buffer, launches projection, waits for triangles,
// rasterisation and z-buffer drain. Optional watchdog enabled by RENDER_WATCHDOG_EN.
module render_frame_sequencer
   import render_pkg::*;
#(
   parameter int unsigned SIZE           = 64,
   parameter int unsigned ADDRW          = 12,
   parameter int unsigned TRI_COUNT      = 2,
   parameter int unsigned DRAIN_CYCLES   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  logic [CAMERA_LOC_W-1:0] camera_loc,
   input  logic                    model_valid,
   input  logic                    raster_busy,
   input  logic                    zbuf_valid,
   output logic                    clear_we,
   output logic                    clear_z,
   output logic [ADDRW-1:0]        clear_addr,
   output logic                    loc_valid,
   output logic [CAMERA_LOC_W-1:0] loc_out,
   output logic                    busy,
   output logic                    frame_done,
   output logic [FRAME_CNT_W-1:0]  frame_count,
   output logic                    overrun,
   output logic                    timeout
);

   localparam int unsigned PIXELS  = SIZE * SIZE;
   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [ADDRW:0] SWEEP_COUNT = (ADDRW+1)'(PIXELS);

   // Elaboration-time parameter sanity
   if (PIXELS > (1 << ADDRW) || TIMEOUT_CYCLES == 0) begin : g_bad_params
      $error("render_frame_sequencer: ADDRW too small for SIZE*SIZE or TIMEOUT_CYCLES is zero");
   end

   seq_state_t             state, state_d;
   camera_loc_t            loc_q;
   logic [TRI_CNT_W-1:0]   tri_q, tri_d, tri_now;
   logic [DRAIN_W-1:0]     drain_q, drain_d, idle_now;
   logic                   sweep_start_c;
   logic                   accept_c;
   logic                   sweep_active;
   logic                   sweep_last;
   logic [ADDRW-1:0]       sweep_addr;

`ifdef RENDER_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_expire_c;
   logic            timeout_q;
`endif

   addr_sweep #(
      .ADDRW (ADDRW)
   ) u_sweep (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (sweep_start_c),
      .count  (SWEEP_COUNT),
      .addr   (sweep_addr),
      .active (sweep_active),
      .last   (sweep_last)
   );

   assign clear_we   = sweep_active;
   assign clear_z    = sweep_active;
   assign clear_addr = sweep_addr;
   assign loc_out    = loc_q;

   // Next-state and counter updates
   always_comb begin
      state_d       = state;
      tri_d         = tri_q;
      drain_d       = drain_q;
      sweep_start_c = 1'b0;
      accept_c      = 1'b0;
      tri_now       = tri_q + TRI_CNT_W'(model_valid);
      idle_now      = zbuf_valid ? '0 : drain_q + DRAIN_W'(1);
`ifdef RENDER_WATCHDOG_EN
      wd_d          = wd_q;
      wd_expire_c   = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (frame_start) begin
               state_d       = CLEAR;
               sweep_start_c = 1'b1;
               accept_c      = 1'b1;
            end
         end
         CLEAR: begin
            if (sweep_last) state_d = LAUNCH;
         end
         LAUNCH: begin
            tri_d   = TRI_CNT_W'(model_valid);
            state_d = WAIT_TRI;
         end
         WAIT_TRI: begin
            tri_d = tri_now;
            if (tri_now >= TRI_CNT_W'(TRI_COUNT)) state_d = RASTER;
         end
         RASTER: begin
            // the cycle that sees raster_busy low already counts toward the drain window
            if (!raster_busy) begin
               state_d = DRAIN;
               drain_d = zbuf_valid ? '0 : DRAIN_W'(1);
            end
         end
         DRAIN: begin
            drain_d = idle_now;
            if (idle_now >= DRAIN_W'(DRAIN_CYCLES)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef RENDER_WATCHDOG_EN
      case (state)
         LAUNCH: wd_d = '0;
         WAIT_TRI, RASTER, DRAIN: begin
            wd_d = wd_q + WD_W'(1);
            if (wd_d >= WD_W'(TIMEOUT_CYCLES)) begin
               wd_expire_c = 1'b1;
               state_d     = DONE;
            end
         end
         default: ;
      endcase
`endif
   end

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tri_q       <= '0;
         drain_q     <= '0;
         loc_q       <= '0;
         loc_valid   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         overrun     <= 1'b0;
      end else begin
         state      <= state_d;
         tri_q      <= tri_d;
         drain_q    <= drain_d;
         loc_valid  <= (state_d == LAUNCH);
         busy       <= (state_d != IDLE);
         frame_done <= (state_d == DONE);
         if (accept_c) loc_q <= camera_loc_t'(camera_loc);
         if (state_d == DONE) frame_count <= frame_count + FRAME_CNT_W'(1);
         if (frame_start && state != IDLE) overrun <= 1'b1;
      end
   end

`ifdef RENDER_WATCHDOG_EN
   // Watchdog counter and sticky abort flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         if (wd_expire_c) timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Self-checking bench for render_frame_sequencer: randomized frames against a timing model.
module tb_render_frame_sequencer;

   localparam int SIZE  = 64;
   localparam int ADDRW = 12;
   localparam int TRI   = 2;
   localparam int DRAIN = 8;
   localparam int TMO   = 100;
   localparam int NPIX  = SIZE * SIZE;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             frame_start = 1'b0;
   logic [29:0]      camera_loc = '0;
   logic             model_valid = 1'b0;
   logic             raster_busy = 1'b0;
   logic             zbuf_valid = 1'b0;
   logic             clear_we, clear_z, loc_valid, busy, frame_done, overrun, timeout;
   logic [ADDRW-1:0] clear_addr;
   logic [29:0]      loc_out;
   logic [7:0]       frame_count;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_count = 0;
   bit exp_overrun = 1'b0;

   // monitor state (written only by the monitor process)
   bit prev_we = 1'b0;
   int run_len = 0, run_first = 0, last_run = 0;
   int addr_err = 0, z_err = 0;
   int lv_cnt = 0, lv_cyc = 0, fd_cnt = 0, fd_cyc = 0;

   render_frame_sequencer #(
      .SIZE           (SIZE),
      .ADDRW          (ADDRW),
      .TRI_COUNT      (TRI),
      .DRAIN_CYCLES   (DRAIN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .camera_loc  (camera_loc),
      .model_valid (model_valid),
      .raster_busy (raster_busy),
      .zbuf_valid  (zbuf_valid),
      .clear_we    (clear_we),
      .clear_z     (clear_z),
      .clear_addr  (clear_addr),
      .loc_valid   (loc_valid),
      .loc_out     (loc_out),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .overrun     (overrun),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Observe clear sweeps, launch pulses and completions mid-cycle
   always @(negedge clk) begin
      if (clear_we) begin
         if (!prev_we) begin
            run_len   = 0;
            run_first = cyc;
         end
         if (clear_addr !== ADDRW'(run_len)) addr_err++;
         run_len++;
      end else if (prev_we) begin
         last_run = run_len;
      end
      if (clear_z !== clear_we) z_err++;
      prev_we = clear_we;
      if (loc_valid) begin
         lv_cnt++;
         lv_cyc = cyc;
      end
      if (frame_done) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [29:0] loc, output int t0);
      frame_start = 1'b1;
      camera_loc  = loc;
      t0          = cyc;
      tick();
      frame_start = 1'b0;
      camera_loc  = 30'($urandom());
   endtask

   // Frame start through loc_valid; optional model_valid in the launch cycle and
   // optional second frame_start when the sweep reaches inject_at.
   task automatic run_clear(input logic [29:0] loc, input bit launch_pulse,
                            input int inject_at, output int t0);
      int b_lv, b_ae, b_ze;
      bit injected;
      b_lv = lv_cnt; b_ae = addr_err; b_ze = z_err; injected = 1'b0;
      start_frame(loc, t0);
      for (int i = 0; i < NPIX + 64 && lv_cnt == b_lv; i++) begin
         model_valid = launch_pulse && (cyc == t0 + NPIX + 1);
         if (inject_at >= 0 && !injected && clear_we && clear_addr == ADDRW'(inject_at)) begin
            frame_start = 1'b1;
            camera_loc  = 30'($urandom());
            injected    = 1'b1;
         end else begin
            frame_start = 1'b0;
         end
         tick();
      end
      model_valid = 1'b0;
      frame_start = 1'b0;
      n_tests++;
      if (lv_cnt - b_lv !== 1) begin
         n_fail++; $display("FAIL loc_valid_pulses: got %0d expected 1", lv_cnt - b_lv);
      end
      n_tests++;
      if (lv_cyc !== t0 + NPIX + 1) begin
         n_fail++; $display("FAIL loc_valid_cycle: got %0d expected %0d", lv_cyc, t0 + NPIX + 1);
      end
      n_tests++;
      if (run_first !== t0 + 1) begin
         n_fail++; $display("FAIL clear_first_cycle: got %0d expected %0d", run_first, t0 + 1);
      end
      n_tests++;
      if (last_run !== NPIX) begin
         n_fail++; $display("FAIL clear_length: got %0d expected %0d", last_run, NPIX);
      end
      n_tests++;
      if (addr_err - b_ae !== 0 || z_err - b_ze !== 0) begin
         n_fail++; $display("FAIL clear_addr_seq: addr errors %0d z errors %0d expected 0 0",
                            addr_err - b_ae, z_err - b_ze);
      end
      n_tests++;
      if (loc_out !== loc) begin
         n_fail++; $display("FAIL loc_out: got %h expected %h", loc_out, loc);
      end
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_in_frame: got %b expected 1", busy);
      end
   endtask

   // Triangles, raster fall and a z-buffer pattern; done = cycle after DRAIN quiet cycles
   task automatic finish_frame(input int kind, input int pre, input logic [29:0] loc);
      logic zq [64];
      int   exp_done, run, f0, b_fd;
      raster_busy = 1'b1;
      b_fd = fd_cnt;
      for (int p = pre; p < TRI; p++) begin
         repeat ($urandom_range(0, 5)) tick();
         model_valid = 1'b1;
         tick();
         model_valid = 1'b0;
      end
      repeat (20) tick();
      for (int j = 0; j < 64; j++) begin
         case (kind)
            0:       zq[j] = 1'b0;
            1:       zq[j] = (j < 40) && (((j / 5) % 2) == 1);
            default: zq[j] = (j < 40) && ($urandom_range(0, 3) == 0);
         endcase
      end
      f0 = cyc;
      exp_done = -1;
      run = 0;
      for (int j = 0; j < 64; j++) begin
         run = zq[j] ? 0 : run + 1;
         if (run == DRAIN && exp_done < 0) exp_done = f0 + j + 1;
      end
      raster_busy = 1'b0;
      for (int j = 0; j < 64; j++) begin
         zbuf_valid = zq[j];
         tick();
      end
      zbuf_valid = 1'b0;
      repeat (3) tick();
      exp_count = (exp_count + 1) % 256;
      n_tests++;
      if (fd_cnt - b_fd !== 1) begin
         n_fail++; $display("FAIL frame_done_pulses: got %0d expected 1", fd_cnt - b_fd);
      end
      n_tests++;
      if (fd_cyc !== exp_done) begin
         n_fail++; $display("FAIL frame_done_cycle: got %0d expected %0d", fd_cyc, exp_done);
      end
      n_tests++;
      if (frame_count !== 8'(exp_count)) begin
         n_fail++; $display("FAIL frame_count: got %0d expected %0d", frame_count, exp_count);
      end
      n_tests++;
      if (busy !== 1'b0 || overrun !== exp_overrun || timeout !== 1'b0) begin
         n_fail++; $display("FAIL post_frame_flags: busy %b overrun %b timeout %b expected 0 %b 0",
                            busy, overrun, timeout, exp_overrun);
      end
      n_tests++;
      if (loc_out !== loc) begin
         n_fail++; $display("FAIL loc_out_hold: got %h expected %h", loc_out, loc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({clear_we, clear_z, loc_valid, frame_done, overrun, timeout, busy} !== 7'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000000",
                            {clear_we, clear_z, loc_valid, frame_done, overrun, timeout, busy});
      end
      n_tests++;
      if (clear_addr !== '0 || loc_out !== '0 || frame_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_values: addr %0d loc %h count %0d expected 0 0 0",
                            clear_addr, loc_out, frame_count);
      end
      rst_n = 1'b1;
      repeat (5) tick();
      n_tests++;
      if (busy !== 1'b0 || clear_we !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: busy %b clear_we %b expected 0 0", busy, clear_we);
      end
   endtask

   task automatic test_clear_launch();
      int t0;
      run_clear(30'h05A13800, 1'b0, -1, t0);
      finish_frame(0, 0, 30'h05A13800);
   endtask

   task automatic test_drain_toggle();
      int t0;
      logic [29:0] loc;
      loc = 30'($urandom());
      run_clear(loc, 1'b0, -1, t0);
      finish_frame(1, 0, loc);
   endtask

   task automatic test_launch_count();
      int t0;
      logic [29:0] loc;
      loc = 30'($urandom());
      run_clear(loc, 1'b1, -1, t0);
      finish_frame(2, 1, loc);
   endtask

   task automatic test_overrun();
      int t0, b_fd;
      logic [29:0] loc;
      loc = 30'($urandom());
      run_clear(loc, 1'b0, 100, t0);
      exp_overrun = 1'b1;
      n_tests++;
      if (overrun !== 1'b1) begin
         n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun);
      end
      finish_frame(2, 0, loc);
      b_fd = fd_cnt;
      repeat (50) tick();
      n_tests++;
      if (busy !== 1'b0 || fd_cnt !== b_fd) begin
         n_fail++; $display("FAIL overrun_no_restart: busy %b extra done %0d expected 0 0",
                            busy, fd_cnt - b_fd);
      end
   endtask

   task automatic test_reset_mid_clear();
      int t0;
      logic [29:0] loc;
      start_frame(30'($urandom()), t0);
      for (int i = 0; i < 2100 && clear_addr != ADDRW'(2000); i++) tick();
      n_tests++;
      if (clear_addr !== ADDRW'(2000)) begin
         n_fail++; $display("FAIL reach_addr_2000: got %0d expected 2000", clear_addr);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({clear_we, clear_z, loc_valid, busy, overrun} !== 5'b0 || clear_addr !== '0
          || frame_count !== 8'd0 || loc_out !== '0) begin
         n_fail++; $display("FAIL async_reset: we %b addr %0d busy %b count %0d loc %h expected all 0",
                            clear_we, clear_addr, busy, frame_count, loc_out);
      end
      exp_count = 0;
      exp_overrun = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      loc = 30'($urandom());
      run_clear(loc, 1'b0, -1, t0);
      finish_frame(2, 0, loc);
   endtask

   task automatic test_watchdog();
      int t0, w0, b_fd;
      run_clear(30'($urandom()), 1'b0, -1, t0);
      w0 = t0 + NPIX + 2;
      b_fd = fd_cnt;
`ifdef RENDER_WATCHDOG_EN
      for (int i = 0; i < 300 && fd_cnt == b_fd; i++) tick();
      repeat (3) tick();
      exp_count = (exp_count + 1) % 256;
      n_tests++;
      if (fd_cnt - b_fd !== 1 || fd_cyc !== w0 + TMO) begin
         n_fail++; $display("FAIL watchdog_done: pulses %0d cycle %0d expected 1 %0d",
                            fd_cnt - b_fd, fd_cyc, w0 + TMO);
      end
      n_tests++;
      if (timeout !== 1'b1 || busy !== 1'b0 || frame_count !== 8'(exp_count)) begin
         n_fail++; $display("FAIL watchdog_flags: timeout %b busy %b count %0d expected 1 0 %0d",
                            timeout, busy, frame_count, exp_count);
      end
`else
      repeat (300) tick();
      n_tests++;
      if (busy !== 1'b1 || fd_cnt !== b_fd || timeout !== 1'b0) begin
         n_fail++; $display("FAIL no_watchdog_wait: busy %b done %0d timeout %b expected 1 0 0 (entry %0d)",
                            busy, fd_cnt - b_fd, timeout, w0);
      end
`endif
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_count = 0;
      tick();
      n_tests++;
      if (busy !== 1'b0 || frame_count !== 8'd0 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL recover_reset: busy %b count %0d timeout %b expected 0 0 0",
                            busy, frame_count, timeout);
      end
   endtask

   initial begin
      test_reset();
      test_clear_launch();
      test_drain_toggle();
      test_launch_count();
      test_overrun();
      test_reset_mid_clear();
      test_watchdog();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
